// File: rtl/nios_system_nios2_mult_pipe.sv
// Pipelined lane-split multiplier for the Nios II MUL/MULXSS/MULXSU/MULXUU ops.
// Optional result accumulator is built when MULT_PIPE_ACC_EN is defined.
module nios_system_nios2_mult_pipe #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned LANE_W      = 16,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic              in_acc,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result
);
    localparam int unsigned NL  = DATA_W / LANE_W;
    localparam int unsigned NPP = NL * NL;
    localparam int unsigned PPW = 2 * LANE_W;
    localparam int unsigned PW  = 2 * DATA_W;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULXSS = 2'b01,
        OP_MULXSU = 2'b10,
        OP_MULXUU = 2'b11
    } op_e;

    logic                   advance;
    op_e                    op_in;
    logic [PIPE_STAGES-1:0] vld_q;
    op_e                    op_q [PIPE_STAGES];
    logic [PPW-1:0]         pp_d [NPP];
    logic [PPW-1:0]         pp_q [NPP];
    logic [DATA_W-1:0]      corr_d;
    logic [DATA_W-1:0]      corr_q;
    logic [PW-1:0]          sum_c;
    logic [PW-1:0]          prod_fin;
    logic [PW-1:0]          fin_val;

    assign op_in     = op_e'(in_op);
    assign out_valid = vld_q[PIPE_STAGES-1];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance && !flush;

    always_comb begin
        for (int unsigned i = 0; i < NL; i++) begin
            for (int unsigned j = 0; j < NL; j++) begin
                pp_d[i*NL+j] = PPW'(in_src1[i*LANE_W +: LANE_W]) * PPW'(in_src2[j*LANE_W +: LANE_W]);
            end
        end
    end

    // Signed operands are multiplied as unsigned; subtracting the other operand
    // from the upper half for each negative signed operand fixes the 2N-bit result.
    always_comb begin
        corr_d = '0;
        if ((op_in == OP_MULXSS || op_in == OP_MULXSU) && in_src1[DATA_W-1]) begin
            corr_d = corr_d - in_src2;
        end
        if (op_in == OP_MULXSS && in_src2[DATA_W-1]) begin
            corr_d = corr_d - in_src1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= '0;
            corr_q <= '0;
            for (int unsigned k = 0; k < PIPE_STAGES; k++) op_q[k] <= OP_MUL;
            for (int unsigned p = 0; p < NPP; p++) pp_q[p] <= '0;
        end else begin
            if (flush) begin
                vld_q <= '0;
            end else if (advance) begin
                vld_q[0] <= in_valid;
                for (int unsigned k = 1; k < PIPE_STAGES; k++) vld_q[k] <= vld_q[k-1];
            end
            if (advance) begin
                pp_q     <= pp_d;
                corr_q   <= corr_d;
                op_q[0]  <= op_in;
                for (int unsigned k = 1; k < PIPE_STAGES; k++) op_q[k] <= op_q[k-1];
            end
        end
    end

    always_comb begin
        sum_c = {corr_q, {DATA_W{1'b0}}};
        for (int unsigned i = 0; i < NL; i++) begin
            for (int unsigned j = 0; j < NL; j++) begin
                sum_c = sum_c + (PW'(pp_q[i*NL+j]) << ((i + j) * LANE_W));
            end
        end
    end

    generate
        if (PIPE_STAGES == 1) begin : g_comb_sum
            assign prod_fin = sum_c;
        end else begin : g_sum_reg
            logic [PW-1:0] prod_q [PIPE_STAGES-1];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int unsigned k = 0; k < PIPE_STAGES - 1; k++) prod_q[k] <= '0;
                end else if (advance) begin
                    prod_q[0] <= sum_c;
                    for (int unsigned k = 1; k < PIPE_STAGES - 1; k++) prod_q[k] <= prod_q[k-1];
                end
            end
            assign prod_fin = prod_q[PIPE_STAGES-2];
        end
    endgenerate

`ifdef MULT_PIPE_ACC_EN
    logic [PIPE_STAGES-1:0] accf_q;
    logic [PW-1:0]          acc_q;

    // The accumulator commits only on the output handshake, so a stalled
    // final-stage beat keeps presenting the same updated value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accf_q <= '0;
            acc_q  <= '0;
        end else begin
            if (advance) begin
                accf_q[0] <= in_acc;
                for (int unsigned k = 1; k < PIPE_STAGES; k++) accf_q[k] <= accf_q[k-1];
            end
            if (out_valid && out_ready) begin
                acc_q <= fin_val;
            end
        end
    end

    assign fin_val = accf_q[PIPE_STAGES-1] ? (acc_q + prod_fin) : prod_fin;
`else
    logic unused_acc;
    assign unused_acc = in_acc;
    assign fin_val    = prod_fin;
`endif

    assign out_result = (op_q[PIPE_STAGES-1] == OP_MUL) ? fin_val[DATA_W-1:0] : fin_val[PW-1:DATA_W];

endmodule

// File: tb/tb_nios_system_nios2_mult_pipe.sv
// Randomized self-checking bench for nios_system_nios2_mult_pipe (32-bit, 16-bit lanes, 2 stages).
// Reference: sign-extended 64-bit multiply plus an in-order queue of beats tracking their stage.
module tb_nios_system_nios2_mult_pipe;
    localparam int unsigned S = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_acc = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  in_op = 2'b00;
    logic [31:0] in_src1 = '0;
    logic [31:0] in_src2 = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_result;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_seen = 0;
    logic        last_acc = 1'b0;
    logic [63:0] macc = '0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        acc;
        int unsigned pos;
        logic        has_k;
        logic [31:0] k;
    } beat_t;

    beat_t q[$];

    always #5 clk = ~clk;

    nios_system_nios2_mult_pipe #(
        .DATA_W      (32),
        .LANE_W      (16),
        .PIPE_STAGES (S)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_acc     (in_acc),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] full_val(input beat_t bt);
        logic [63:0] ea, eb, p;
        ea = (bt.op == 2'b01 || bt.op == 2'b10) ? {{32{bt.a[31]}}, bt.a} : {32'h0, bt.a};
        eb = (bt.op == 2'b01) ? {{32{bt.b[31]}}, bt.b} : {32'h0, bt.b};
        p  = ea * eb;
`ifdef MULT_PIPE_ACC_EN
        if (bt.acc) p = p + macc;
`endif
        return p;
    endfunction

    function automatic logic [31:0] word_of(input logic [1:0] op, input logic [63:0] v);
        return (op == 2'b00) ? v[31:0] : v[63:32];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic step(input logic iv, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic acc, input logic ordy, input logic fl,
                        input logic hk, input logic [31:0] k);
        logic        exp_ov;
        logic [63:0] fv;
        beat_t       nb;
        @(negedge clk);
        in_valid = iv; in_op = op; in_src1 = a; in_src2 = b;
        in_acc = acc; out_ready = ordy; flush = fl;
        #1;
        exp_ov = (q.size() > 0) && (q[0].pos == S);
        check("out_valid", 64'(out_valid), 64'(exp_ov));
        check("in_ready", 64'(in_ready), 64'((!exp_ov || ordy) && !fl));
        fv = '0;
        if (exp_ov) begin
            fv = full_val(q[0]);
            check("out_result", 64'(out_result), 64'(word_of(q[0].op, fv)));
            if (q[0].has_k) check("known_result", 64'(out_result), 64'(q[0].k));
        end
        last_acc = iv && in_ready;
        if (out_valid && ordy) n_seen++;
        @(posedge clk);
        if (exp_ov && ordy) begin
            macc = fv;
            void'(q.pop_front());
        end
        if (fl) begin
            q.delete();
        end else if (!exp_ov || ordy) begin
            foreach (q[i]) q[i].pos++;
            if (iv) begin
                nb.op = op; nb.a = a; nb.b = b; nb.acc = acc;
                nb.pos = 1; nb.has_k = hk; nb.k = k;
                q.push_back(nb);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        q.delete();
        macc = '0;
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sa [4];
        logic [31:0] sb [4];
        int          idx;
        int          s0;
        logic [31:0] ra, rb;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_result", 64'(out_result), 64'd0);
        #1 reset = 1'b0;

        // all-ones operands on every op, back to back
        step(1'b1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0001);
        step(1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
        step(1'b1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000);
        step(1'b1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        idle(3);

        // most-negative operands
        step(1'b1, 2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4000_0000);
        step(1'b1, 2'b11, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4000_0000);
        step(1'b1, 2'b10, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 32'hC000_0000);
        idle(3);

        // four beats with a three-cycle consumer stall after the first result
        sa[0] = 32'd3;         sb[0] = 32'd7;
        sa[1] = 32'hFFFF_0001; sb[1] = 32'h0001_FFFF;
        sa[2] = 32'h1234_5678; sb[2] = 32'h9ABC_DEF0;
        sa[3] = 32'h8000_0001; sb[3] = 32'hFFFF_FFFE;
        idx = 0;
        s0  = n_seen;
        for (int c = 0; c < 14; c++) begin
            step(idx < 4, 2'(idx), sa[idx % 4], sb[idx % 4], 1'b0, !(c >= 2 && c <= 4), 1'b0, 1'b0, '0);
            if (last_acc) idx++;
        end
        check("stall_accepted", 64'(idx), 64'd4);
        check("stall_delivered", 64'(n_seen - s0), 64'd4);

        // flush with two beats in flight, then a fresh beat
        step(1'b1, 2'b00, 32'd7, 32'd9, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 2'b00, 32'd11, 32'd13, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 2'b00, 32'd99, 32'd99, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        step(1'b1, 2'b00, 32'd6, 32'd7, 1'b0, 1'b1, 1'b0, 1'b1, 32'd42);
        idle(4);

        // asynchronous reset with two beats in flight
        step(1'b1, 2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 2'b00, 32'd5, 32'd5, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        mid_reset();
        idle(4);

        // accumulate sequence
        step(1'b1, 2'b00, 32'd3, 32'd4, 1'b0, 1'b1, 1'b0, 1'b1, 32'd12);
`ifdef MULT_PIPE_ACC_EN
        step(1'b1, 2'b00, 32'd5, 32'd6, 1'b1, 1'b1, 1'b0, 1'b1, 32'd42);
`else
        step(1'b1, 2'b00, 32'd5, 32'd6, 1'b1, 1'b1, 1'b0, 1'b1, 32'd30);
`endif
        idle(3);

        for (int c = 0; c < 600; c++) begin
            ra = pick();
            rb = pick();
            step($urandom_range(0, 99) < 70, 2'($urandom_range(0, 3)), ra, rb,
                 1'($urandom_range(0, 1)), $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 4, 1'b0, '0);
        end
        idle(6);
        check("drained", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/nios_system_nios2_mult_pipe.md
NIOS_SYSTEM_NIOS2_MULT_PIPE -- requirements
Module: nios_system_nios2_mult_pipe

Interface
REQ-001 Parameter DATA_W, default 32, meaning operand and result width, even, 16..64.
REQ-002 Parameter LANE_W, default 16, meaning partial-product lane width, divides DATA_W.
REQ-003 Parameter PIPE_STAGES, default 2, meaning register stages from input to output, 1..4.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 flush  in  1  synchronous pipeline invalidate.
REQ-007 in_valid  in  1  operand beat present.
REQ-008 in_ready  out  1  block accepts a beat this cycle.
REQ-009 in_op  in  2  00 MUL low word, 01 MULXSS, 10 MULXSU, 11 MULXUU (high word).
REQ-010 in_acc  in  1  accumulate product (MULT_PIPE_ACC_EN only).
REQ-011 in_src1, in_src2  in  DATA_W  operands.
REQ-012 out_valid  out  1  result beat present.
REQ-013 out_ready  in  1  consumer accepts result.
REQ-014 out_result  out  DATA_W  selected result word.

Function
REQ-015 Beat accepted when in_valid && in_ready; result delivered when out_valid && out_ready.
REQ-016 advance = !out_valid || out_ready; in_ready SHALL equal advance && !flush.
REQ-017 When advance=1, every stage and its valid bit SHALL shift one position; when 0, all stages SHALL hold.
REQ-018 Latency SHALL be exactly PIPE_STAGES cycles from acceptance to out_valid when no stall occurs; throughput one beat per cycle.
REQ-019 Product SHALL be formed from (DATA_W/LANE_W)^2 unsigned LANE_W x LANE_W partial products registered in stage 1 and summed to a 2*DATA_W product by the final stage.
REQ-020 Sign handling: MULXSS treats both operands signed; MULXSU treats src1 signed, src2 unsigned; MULXUU and MUL both unsigned; correction terms applied before final sum.
REQ-021 MUL SHALL return product[DATA_W-1:0]; MULX* SHALL return product[2*DATA_W-1:DATA_W].
REQ-022 flush=1 SHALL clear all valid bits at the next edge regardless of out_ready; data registers are don't-care.
REQ-023 Simultaneous flush and in_valid: beat is not accepted (in_ready=0).
REQ-024 Beat in final stage with out_ready=0 SHALL keep out_result stable until handshake.
REQ-025 Bubbles SHALL NOT be collapsed; an invalid stage still consumes one advance.

Reset
REQ-026 reset SHALL asynchronously clear all valid bits, out_valid=0, out_result=0, accumulator=0.
REQ-027 reset asserted mid-operation SHALL discard all in-flight beats; no result emerges after release.
REQ-028 in_ready SHALL be 1 in the first cycle after reset release (flush=0).

Configuration
REQ-029 Macro MULT_PIPE_ACC_EN defined: 2*DATA_W accumulator; beat with in_acc=1 SHALL add its signed/unsigned product (per in_op) to the accumulator when it leaves the final stage, wrapping modulo 2^(2*DATA_W), and out_result SHALL select the word of the updated accumulator.
REQ-030 Beat with in_acc=0 SHALL load the accumulator with its product (restart).
REQ-031 Macro undefined: no accumulator logic; in_acc ignored; out_result from product only.
REQ-032 flush SHALL NOT clear the accumulator; only reset does.

Verification (DATA_W=32, LANE_W=16, PIPE_STAGES=2)
REQ-033 0xFFFFFFFF x 0xFFFFFFFF, ops MUL/MULXUU/MULXSS/MULXSU -> 0x00000001 / 0xFFFFFFFE / 0x00000000 / 0xFFFFFFFF, each 2 cycles after acceptance.
REQ-034 Four back-to-back beats, out_ready=0 for 3 cycles after first out_valid -> in_ready=0 during stall, out_result held, all four results in order, none lost or duplicated.
REQ-035 Two beats in flight, flush=1 one cycle -> out_valid stays 0, next accepted beat returns correct result 2 cycles later.
REQ-036 reset pulse with two beats in flight -> out_valid=0, out_result=0 immediately; no stale result after release.
REQ-037 MULT_PIPE_ACC_EN: 3x4 in_acc=0 then 5x6 in_acc=1, op MUL -> results 12 then 42; without macro -> 12 then 30.
REQ-038 0x80000000 x 0x80000000 MULXSS -> 0x40000000; MULXUU -> 0x40000000; MULXSU -> 0xC0000000.
